lct_l1a_matcher: RTL and testbench
==================================

# lct_l1a_matcher

Synthesizable consumer of the per-event trigger stream (`l1a`, `lct[7:0]`) produced by the bench event generator, and later by the real trigger front end. For each L1A it looks back into an LCT history window at a fixed LCT-to-L1A latency. It produces a per-channel match mask tagged with a running L1A number. Results are emitted as a one-cycle pulse and queued in a 16-deep show-ahead FIFO for the readout controller.

## Interface
- `LCT_L1A_DLY`, default 100: cycles from an LCT to its L1A. Legal range is 1..255.
- `WIN`, default 5: match window width in cycles. Legal range is 1..15.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: when low, `l1a` is ignored. History still shifts.
- `l1a`, in, 1: L1A strobe, one cycle per trigger.
- `lct`, in, 8: per-channel LCT strobes. Bit 0 is the OTMB global LCT; bits 7:1 are the DCFEB channels.
- `l1a_match_vld`, out, 1: one-cycle pulse, one per accepted L1A.
- `l1a_match`, out, 8: per-channel match mask. Valid while `l1a_match_vld` is high.
- `l1a_cnt`, out, 24: L1A number of the current result.
- `fifo_rd_en`, in, 1: pops the FIFO head.
- `fifo_dout`, out, 32: FIFO head, formatted as {l1a_cnt[23:0], l1a_match[7:0]}. Valid while `fifo_empty` is low.
- `fifo_empty`, out, 1: FIFO empty flag.
- `fifo_full`, out, 1: FIFO full flag.
- `ovf_cnt`, out, 8: count of dropped results. Saturates.

## Operation
- **History register.**
  - Each channel has a shift register of depth `LCT_L1A_DLY+WIN`, sampled every edge regardless of `en`.
  - `h[k]` is the `lct` value sampled k edges before the current edge; k=0 is the current edge.
- **Acceptance.** An L1A is accepted when `l1a && en` is sampled high at edge t.
- **Match rule.** For an L1A accepted at edge t: `match[i] = OR of lct[i]` sampled at edges t-`LCT_L1A_DLY`-`WIN`+1 through t-`LCT_L1A_DLY`, inclusive.
  - LCTs outside the window never match.
  - An all-zero mask is still a valid result.
- **L1A counter.**
  - Increments on every accepted L1A.
  - The first L1A after reset is numbered 1.
  - Wraps from 0xFFFFFF to 0x000000.
- **Pulse output.** `l1a_match`, `l1a_cnt` and `l1a_match_vld` are registered together. They hold their values between pulses; only `vld` returns to 0.
- **Back-to-back L1As.** Each one yields its own result; consecutive results are independent.
- **FIFO.**
  - Depth is 16 entries. Every result is pushed on the same edge that raises `l1a_match_vld`.
  - Show-ahead: `fifo_dout` is the oldest entry whenever not empty, and `fifo_rd_en` advances it on the next edge.
  - `fifo_rd_en` while empty is ignored.
  - Push and pop in the same cycle while full: both take effect, nothing is dropped, and occupancy stays 16.
  - Push while full with no pop: the result is dropped and `ovf_cnt` increments, saturating at 255. The pulse outputs still fire for a dropped result.
  - Push and pop in the same cycle while empty: the pop is ignored and occupancy becomes 1.
- **Reset (`rstn` low), asynchronous, including mid-operation:**
  - Clears the history and sets `l1a_cnt=0`.
  - Sets `l1a_match=0` and `l1a_match_vld=0`.
  - Clears the FIFO: `fifo_empty=1`, `fifo_full=0`, `fifo_dout=0`.
  - Sets `ovf_cnt=0`.
  - Windows that straddle reset see zeros for pre-reset cycles.

## Timing
- Accepted L1A sampled at edge t:
  - `l1a_match_vld` is high for the cycle after edge t+1.
  - The entry is written at edge t+1, so `fifo_empty` deasserts after edge t+1 if the FIFO was empty.
- Read latency:
  - `fifo_rd_en` sampled at edge r makes the next entry visible after edge r.
  - `fifo_empty` updates at edge r.
- `fifo_full` asserts after the edge that writes the 16th entry.
- `ovf_cnt` updates on the same edge as the dropped push.
- There is no combinational path from inputs to outputs.

## Test plan
- **Window edges.** Defaults; `lct[3]` pulsed at edge 200; L1A at edges 300, 304, 305 and 299 in separate runs.
  - L1A at 300 or 304 -> mask 0x08.
  - L1A at 305 or 299 -> mask 0x00; the result is still pushed.
- **Multi-channel, back-to-back.** `lct=0x81` at edge 50, `lct=0x02` at edge 52; L1As at 152 and 153.
  - 152 -> mask 0x83, cnt 1.
  - 153 -> mask 0x83, cnt 2.
  - Two FIFO entries: 0x00000183, 0x00000283.
- **Overflow.** 18 L1As with no reads -> `fifo_full=1` after the 16th, `ovf_cnt=2`, and the FIFO head has cnt 1. Then an L1A pushed with simultaneous `fifo_rd_en` while full -> nothing dropped, `ovf_cnt` stays 2.
- **Enable gating and empty read.** L1A with `en=0` -> no pulse, `l1a_cnt` unchanged. `fifo_rd_en` while empty -> no state change.
- **Reset mid-operation.** `rstn` low for 3 cycles while the FIFO holds 5 entries and an LCT sits in the history -> all outputs at reset values. The next L1A yields cnt 1 and mask 0x00.
- **Counter wrap.** Preload or force `l1a_cnt=0xFFFFFF`; one L1A -> reported cnt 0x000000.

Source files
------------

// File: rtl/lct_l1a_matcher_if.sv
// Trigger-stream input and readout-side signal bundle for lct_l1a_matcher.
// master = trigger source / readout controller, slave = matcher.
interface lct_l1a_matcher_if;
  logic        en;
  logic        l1a;
  logic [7:0]  lct;
  logic        fifo_rd_en;
  logic        l1a_match_vld;
  logic [7:0]  l1a_match;
  logic [23:0] l1a_cnt;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  ovf_cnt;

  modport master (
    output en, l1a, lct, fifo_rd_en,
    input  l1a_match_vld, l1a_match, l1a_cnt, fifo_dout, fifo_empty, fifo_full, ovf_cnt
  );

  modport slave (
    input  en, l1a, lct, fifo_rd_en,
    output l1a_match_vld, l1a_match, l1a_cnt, fifo_dout, fifo_empty, fifo_full, ovf_cnt
  );
endinterface

// File: rtl/lct_l1a_matcher.sv
// Matches each accepted L1A against an LCT history window at fixed latency and
// queues {l1a_cnt, mask} results in a 16-deep show-ahead FIFO.
module lct_l1a_matcher #(
  parameter int unsigned LCT_L1A_DLY = 100,
  parameter int unsigned WIN         = 5
) (
  input  logic                clk,
  input  logic                rstn,
  lct_l1a_matcher_if.slave    bus
);

  localparam int unsigned DEPTH      = LCT_L1A_DLY + WIN;
  localparam int unsigned FIFO_DEPTH = 16;

  logic [DEPTH-1:0][7:0] hist;
  logic                  acc_q;
  logic [7:0]            win_or;
  logic [23:0]           cnt_nxt;

  logic                  vld_q;
  logic [7:0]            match_q;
  logic [23:0]           l1a_cnt_q;

  logic [31:0]           mem [FIFO_DEPTH];
  logic [3:0]            wr_ptr;
  logic [3:0]            rd_ptr;
  logic [4:0]            fill;
  logic [7:0]            ovf_q;
  logic                  push;
  logic                  pop;
  logic                  wr_ok;
  logic                  empty;
  logic                  full;

  // hist[k] holds lct sampled k edges before the most recent edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= '0;
    end else begin
      hist <= {hist[DEPTH-2:0], bus.lct};
    end
  end

  // Evaluated one edge after acceptance, so the window sits at hist[DLY .. DLY+WIN-1]
  always_comb begin
    win_or = '0;
    for (int unsigned k = LCT_L1A_DLY; k < DEPTH; k++) begin
      win_or = win_or | hist[k];
    end
  end

  assign cnt_nxt = l1a_cnt_q + 24'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= 1'b0;
      vld_q     <= 1'b0;
      match_q   <= '0;
      l1a_cnt_q <= '0;
    end else begin
      acc_q <= bus.l1a & bus.en;
      vld_q <= acc_q;
      if (acc_q) begin
        match_q   <= win_or;
        l1a_cnt_q <= cnt_nxt;
      end
    end
  end

  assign empty = (fill == 5'd0);
  assign full  = (fill == 5'(FIFO_DEPTH));
  assign push  = acc_q;
  assign pop   = bus.fifo_rd_en & ~empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign wr_ok = push & (~full | pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      ovf_q  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 4'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 4'd1;
      end
      case ({wr_ok, pop})
        2'b10:   fill <= fill + 5'd1;
        2'b01:   fill <= fill - 5'd1;
        default: fill <= fill;
      endcase
      if (push && !wr_ok && ovf_q != 8'hFF) begin
        ovf_q <= ovf_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {cnt_nxt, win_or};
    end
  end

  assign bus.l1a_match_vld = vld_q;
  assign bus.l1a_match     = match_q;
  assign bus.l1a_cnt       = l1a_cnt_q;
  assign bus.fifo_dout     = empty ? '0 : mem[rd_ptr];
  assign bus.fifo_empty    = empty;
  assign bus.fifo_full     = full;
  assign bus.ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_lct_l1a_matcher.sv
// Directed bench for lct_l1a_matcher: window-edge table plus hand-written
// sequences for back-to-back, overflow, gating, mid-op reset and counter wrap.
module tb_lct_l1a_matcher;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  lct_l1a_matcher_if bus ();

  lct_l1a_matcher #(.LCT_L1A_DLY(100), .WIN(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned delta;
    logic [7:0]  lct_val;
    logic [7:0]  exp_mask;
  } win_vec_t;

  win_vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_lct(input logic [7:0] v);
    bus.lct = v;
    @(negedge clk);
    bus.lct = '0;
  endtask

  task automatic fire_l1a();
    bus.l1a = 1'b1;
    @(negedge clk);
    bus.l1a = 1'b0;
  endtask

  task automatic pop_one();
    bus.fifo_rd_en = 1'b1;
    @(negedge clk);
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld"},   32'(bus.l1a_match_vld), 32'd0);
    chk({tag, "_match"}, 32'(bus.l1a_match),     32'd0);
    chk({tag, "_cnt"},   32'(bus.l1a_cnt),       32'd0);
    chk({tag, "_empty"}, 32'(bus.fifo_empty),    32'd1);
    chk({tag, "_full"},  32'(bus.fifo_full),     32'd0);
    chk({tag, "_dout"},  bus.fifo_dout,          32'd0);
    chk({tag, "_ovf"},   32'(bus.ovf_cnt),       32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.en = 1'b0;
    bus.l1a = 1'b0;
    bus.lct = '0;
    bus.fifo_rd_en = 1'b0;
    idle(3);
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{delta: 100, lct_val: 8'h08, exp_mask: 8'h08};
    vecs[1] = '{delta: 104, lct_val: 8'h08, exp_mask: 8'h08};
    vecs[2] = '{delta: 105, lct_val: 8'h08, exp_mask: 8'h00};
    vecs[3] = '{delta:  99, lct_val: 8'h08, exp_mask: 8'h00};
    vecs[4] = '{delta: 102, lct_val: 8'hFF, exp_mask: 8'hFF};
    vecs[5] = '{delta: 103, lct_val: 8'h01, exp_mask: 8'h01};

    rstn = 1'b0;
    bus.en = 1'b0;
    bus.l1a = 1'b0;
    bus.lct = '0;
    bus.fifo_rd_en = 1'b0;
    idle(3);
    chk_reset_vals("rst0");
    rstn = 1'b1;

    // Window edges: LCT at edge E, L1A at edge E+delta
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.en = 1'b1;
      idle(20);
      pulse_lct(vecs[i].lct_val);
      idle(vecs[i].delta - 1);
      fire_l1a();
      @(negedge clk);
      chk("win_vld",  32'(bus.l1a_match_vld), 32'd1);
      chk("win_mask", 32'(bus.l1a_match),     32'(vecs[i].exp_mask));
      chk("win_cnt",  32'(bus.l1a_cnt),       32'd1);
      chk("win_fifo", bus.fifo_dout,          {24'd1, vecs[i].exp_mask});
      @(negedge clk);
      chk("win_vld_low",   32'(bus.l1a_match_vld), 32'd0);
      chk("win_mask_hold", 32'(bus.l1a_match),     32'(vecs[i].exp_mask));
    end

    // Multi-channel, back-to-back L1As at E+102 and E+103
    do_reset();
    bus.en = 1'b1;
    idle(5);
    bus.lct = 8'h81;
    @(negedge clk);
    bus.lct = 8'h00;
    @(negedge clk);
    bus.lct = 8'h02;
    @(negedge clk);
    bus.lct = 8'h00;
    idle(99);
    bus.l1a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.l1a = 1'b0;
    chk("b2b_vld1",  32'(bus.l1a_match_vld), 32'd1);
    chk("b2b_mask1", 32'(bus.l1a_match),     32'h83);
    chk("b2b_cnt1",  32'(bus.l1a_cnt),       32'd1);
    @(negedge clk);
    chk("b2b_vld2",  32'(bus.l1a_match_vld), 32'd1);
    chk("b2b_mask2", 32'(bus.l1a_match),     32'h83);
    chk("b2b_cnt2",  32'(bus.l1a_cnt),       32'd2);
    @(negedge clk);
    chk("b2b_vld_low", 32'(bus.l1a_match_vld), 32'd0);
    chk("b2b_head1",   bus.fifo_dout,          32'h0000_0183);
    pop_one();
    chk("b2b_head2",   bus.fifo_dout,          32'h0000_0283);
    pop_one();
    chk("b2b_empty",   32'(bus.fifo_empty),    32'd1);
    chk("b2b_dout0",   bus.fifo_dout,          32'd0);

    // Overflow: 16 pushes fill the FIFO, 2 more are dropped
    do_reset();
    bus.en = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) begin
      fire_l1a();
      @(negedge clk);
      chk("ovf_fill_full", 32'(bus.fifo_full), 32'(i == 15));
    end
    chk("ovf_none_yet", 32'(bus.ovf_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      fire_l1a();
      @(negedge clk);
      chk("ovf_drop_vld", 32'(bus.l1a_match_vld), 32'd1);
    end
    chk("ovf_cnt2",  32'(bus.ovf_cnt),    32'd2);
    chk("ovf_full",  32'(bus.fifo_full),  32'd1);
    chk("ovf_head",  bus.fifo_dout,       {24'd1, 8'h00});
    chk("ovf_l1a18", 32'(bus.l1a_cnt),    32'd18);
    // Push with simultaneous pop while full
    bus.l1a = 1'b1;
    @(negedge clk);
    bus.l1a = 1'b0;
    bus.fifo_rd_en = 1'b1;
    @(negedge clk);
    bus.fifo_rd_en = 1'b0;
    chk("pp_full_ovf",  32'(bus.ovf_cnt),   32'd2);
    chk("pp_full_full", 32'(bus.fifo_full), 32'd1);
    chk("pp_full_cnt",  32'(bus.l1a_cnt),   32'd19);
    chk("pp_full_head", bus.fifo_dout,      {24'd2, 8'h00});
    // Saturation of the drop counter
    bus.l1a = 1'b1;
    idle(260);
    bus.l1a = 1'b0;
    idle(2);
    chk("ovf_sat",     32'(bus.ovf_cnt), 32'd255);
    chk("ovf_sat_cnt", 32'(bus.l1a_cnt), 32'd279);
    for (int i = 0; i < 16; i++) begin
      chk("drain_head", bus.fifo_dout, {((i < 15) ? 24'(i + 2) : 24'd19), 8'h00});
      pop_one();
    end
    chk("drain_empty", 32'(bus.fifo_empty), 32'd1);
    chk("drain_full",  32'(bus.fifo_full),  32'd0);

    // Enable gating
    bus.en = 1'b0;
    fire_l1a();
    idle(2);
    chk("en_vld", 32'(bus.l1a_match_vld), 32'd0);
    chk("en_cnt", 32'(bus.l1a_cnt),       32'd279);
    bus.en = 1'b1;
    // Read while empty
    pop_one();
    chk("rd_empty_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rd_empty_dout",  bus.fifo_dout,       32'd0);
    chk("rd_empty_ovf",   32'(bus.ovf_cnt),    32'd255);
    // Push and pop on the same edge while empty
    bus.l1a = 1'b1;
    @(negedge clk);
    bus.l1a = 1'b0;
    bus.fifo_rd_en = 1'b1;
    @(negedge clk);
    bus.fifo_rd_en = 1'b0;
    chk("pp_empty_empty", 32'(bus.fifo_empty), 32'd0);
    chk("pp_empty_head",  bus.fifo_dout,       {24'd280, 8'h00});
    pop_one();
    chk("pp_empty_drain", 32'(bus.fifo_empty), 32'd1);

    // Reset mid-operation with 5 entries queued and an LCT in history
    pulse_lct(8'h10);
    for (int i = 0; i < 5; i++) begin
      fire_l1a();
      @(negedge clk);
    end
    chk("mid_pre_empty", 32'(bus.fifo_empty), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    idle(3);
    rstn = 1'b1;
    idle(86);
    fire_l1a();
    @(negedge clk);
    chk("mid_post_vld",  32'(bus.l1a_match_vld), 32'd1);
    chk("mid_post_cnt",  32'(bus.l1a_cnt),       32'd1);
    chk("mid_post_mask", 32'(bus.l1a_match),     32'd0);

    // Counter wrap
    @(negedge clk);
    force dut.l1a_cnt_q = 24'hFF_FFFF;
    #1;
    release dut.l1a_cnt_q;
    fire_l1a();
    @(negedge clk);
    chk("wrap_vld", 32'(bus.l1a_match_vld), 32'd1);
    chk("wrap_cnt", 32'(bus.l1a_cnt),       32'd0);
    chk("wrap_head", bus.fifo_dout,         {24'd1, 8'h00});
    pop_one();
    chk("wrap_fifo", bus.fifo_dout,         32'd0);
    chk("wrap_fifo_nonempty", 32'(bus.fifo_empty), 32'd0);
    fire_l1a();
    @(negedge clk);
    chk("wrap_next", 32'(bus.l1a_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
